// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: widths, NOP encoding, base opcodes and fetch FSM states.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_FULL  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset to RESET_PC, load beats increment.
module pc_reg #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   input  logic            inc,
   output logic [XLEN-1:0] pc
);
   // Increment wraps naturally at 2^XLEN.
   always_ff @(posedge clk) begin
      if (rst)       pc <= RESET_PC;
      else if (load) pc <= load_pc;
      else if (inc)  pc <= pc + XLEN'(4);
   end
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with one-entry holding register and redirect flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = riscv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [6:0]      if_opcode
);
   import riscv_pkg::*;

   fetch_state_t    state, state_n;
   logic            req, capture;
   logic [XLEN-1:0] pc;

   pc_reg #(.XLEN(XLEN), .RESET_PC(XLEN'(RESET_PC))) u_pc (
      .clk     (clk),
      .rst     (rst),
      .load    (redirect_valid),
      .load_pc (redirect_pc & ~XLEN'(3)),
      .inc     (capture),
      .pc      (pc)
   );

   // Redirect outranks every other event in every state.
   always_comb begin
      state_n = state;
      req     = 1'b0;
      capture = 1'b0;
      case (state)
         S_REQ: begin
            req = !redirect_valid;
            if (!redirect_valid && imem_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid)   state_n = imem_rvalid ? S_REQ : S_DRAIN;
            else if (imem_rvalid) begin
               capture = 1'b1;
               state_n = S_FULL;
            end
         end
         S_FULL:  if (redirect_valid || !stall) state_n = S_REQ;
         S_DRAIN: if (imem_rvalid) state_n = S_REQ;
         default: state_n = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_instr <= XLEN'(NOP_INSTR);
      end else begin
         state    <= state_n;
         if_valid <= (state_n == S_FULL);
         if (capture) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
         end
      end
   end

   assign imem_req  = req && !rst;
   assign imem_addr = pc;
   assign if_opcode = if_instr[6:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: per-cycle table plus wrap and mid-transaction reset sequences.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst, imem_req, imem_ready, imem_rvalid, redirect_valid, stall, if_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;
   logic [6:0]  if_opcode;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode)
   );

   typedef struct {
      logic        rdy, rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        stl;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc, e_ins;
   } vec_t;

   vec_t vt[23];

   function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic redir,
                               logic [31:0] rpc, logic stl, logic e_req, logic [31:0] e_addr,
                               logic e_vld, logic [31:0] e_pc, logic [31:0] e_ins);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.stl = stl;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_ins = e_ins;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive at the falling edge, sample 1ns later (well away from the rising edge).
   task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] rpc, input logic stl);
      @(negedge clk);
      rst = r; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
      redirect_valid = redir; redirect_pc = rpc; stall = stl;
      #1;
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;

      vt[0]  = mk(1,0,32'h0,        0,32'h0,  0, 1,32'h000, 0,32'h0,  32'h0);
      vt[1]  = mk(0,1,32'h00500093, 0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
      vt[2]  = mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,   1,32'h000,32'h00500093);
      vt[3]  = mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,   1,32'h000,32'h00500093);
      vt[4]  = mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,   1,32'h000,32'h00500093);
      vt[5]  = mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,   1,32'h000,32'h00500093);
      vt[6]  = mk(1,0,32'h0,        0,32'h0,  1, 0,32'h0,   1,32'h000,32'h00500093);
      vt[7]  = mk(0,0,32'h0,        0,32'h0,  0, 0,32'h0,   1,32'h000,32'h00500093);
      vt[8]  = mk(1,0,32'h0,        0,32'h0,  0, 1,32'h004, 0,32'h0,  32'h0);
      vt[9]  = mk(0,0,32'h0,        1,32'h103,0, 0,32'h0,   0,32'h0,  32'h0);
      vt[10] = mk(0,1,32'hDEADBEEF, 0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
      vt[11] = mk(0,0,32'h0,        0,32'h0,  0, 1,32'h100, 0,32'h0,  32'h0);
      vt[12] = mk(1,0,32'h0,        0,32'h0,  0, 1,32'h100, 0,32'h0,  32'h0);
      vt[13] = mk(0,1,32'h00A00113, 0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
      vt[14] = mk(0,0,32'h0,        0,32'h0,  0, 0,32'h0,   1,32'h100,32'h00A00113);
      vt[15] = mk(1,0,32'h0,        0,32'h0,  0, 1,32'h104, 0,32'h0,  32'h0);
      vt[16] = mk(0,1,32'hBAD00037, 1,32'h200,0, 0,32'h0,   0,32'h0,  32'h0);
      vt[17] = mk(0,0,32'h0,        0,32'h0,  0, 1,32'h200, 0,32'h0,  32'h0);
      vt[18] = mk(1,0,32'h0,        1,32'h302,0, 0,32'h0,   0,32'h0,  32'h0);
      vt[19] = mk(1,0,32'h0,        0,32'h0,  0, 1,32'h300, 0,32'h0,  32'h0);
      vt[20] = mk(0,1,32'h0000006F, 0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0);
      vt[21] = mk(0,0,32'h0,        1,32'h400,1, 0,32'h0,   1,32'h300,32'h0000006F);
      vt[22] = mk(0,0,32'h0,        0,32'h0,  0, 1,32'h400, 0,32'h0,  32'h0);

      // Reset state, with imem_ready high to show the request is gated by rst.
      step(1, 1, 0, 32'h0, 0, 32'h0, 0);
      chk("rst req",    {31'b0, imem_req}, 32'h0);
      chk("rst vld",    {31'b0, if_valid}, 32'h0);
      chk("rst if_pc",  if_pc, 32'h0);
      chk("rst instr",  if_instr, 32'h0000_0013);
      chk("rst opcode", {25'b0, if_opcode}, 32'h13);

      foreach (vt[i]) begin
         step(0, vt[i].rdy, vt[i].rv, vt[i].rdata, vt[i].redir, vt[i].rpc, vt[i].stl);
         chk($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vt[i].e_req});
         chk($sformatf("v%0d vld", i), {31'b0, if_valid}, {31'b0, vt[i].e_vld});
         if (vt[i].e_req) chk($sformatf("v%0d addr", i), imem_addr, vt[i].e_addr);
         if (vt[i].e_vld) begin
            chk($sformatf("v%0d if_pc", i), if_pc, vt[i].e_pc);
            chk($sformatf("v%0d instr", i), if_instr, vt[i].e_ins);
            chk($sformatf("v%0d opcode", i), {25'b0, if_opcode}, {25'b0, vt[i].e_ins[6:0]});
         end
      end

      // PC wrap: redirect (low bits masked) to the last word, fetch it, next address is 0.
      step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFE, 0);
      chk("wrap redir req", {31'b0, imem_req}, 32'h0);
      step(0, 1, 0, 32'h0, 0, 32'h0, 0);
      chk("wrap req",  {31'b0, imem_req}, 32'h1);
      chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 1, 32'h0000_0013, 0, 32'h0, 0);
      chk("wrap wait vld", {31'b0, if_valid}, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("wrap vld",   {31'b0, if_valid}, 32'h1);
      chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("wrap next req",  {31'b0, imem_req}, 32'h1);
      chk("wrap next addr", imem_addr, 32'h0);

      // Reset while waiting on a response; the late response must be ignored.
      step(0, 0, 0, 32'h0, 1, 32'h80, 0);
      step(0, 1, 0, 32'h0, 0, 32'h0, 0);
      chk("mid req",  {31'b0, imem_req}, 32'h1);
      chk("mid addr", imem_addr, 32'h80);
      step(1, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("mid rst req", {31'b0, imem_req}, 32'h0);
      step(0, 0, 1, 32'h1234_5678, 0, 32'h0, 0);
      chk("post rst req",  {31'b0, imem_req}, 32'h1);
      chk("post rst addr", imem_addr, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("post rst vld",   {31'b0, if_valid}, 32'h0);
      chk("post rst instr", if_instr, 32'h0000_0013);
      chk("post rst if_pc", if_pc, 32'h0);
      chk("post rst addr2", imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter XLEN, default 32, is the address and instruction width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  XLEN  fetch address; valid while imem_req=1.
REQ-008 imem_ready  in  1  memory accepts the request in the current cycle.
REQ-009 imem_rvalid  in  1  read data valid, one response per accepted request.
REQ-010 imem_rdata  in  XLEN  fetched instruction word.
REQ-011 redirect_valid  in  1  branch/jump redirect strobe.
REQ-012 redirect_pc  in  XLEN  redirect target.
REQ-013 stall  in  1  decode/control stage cannot accept the held instruction.
REQ-014 if_valid  out  1  held instruction is valid for decode.
REQ-015 if_pc  out  XLEN  address of the held instruction.
REQ-016 if_instr  out  XLEN  held instruction word.
REQ-017 if_opcode  out  7  if_instr[6:0], the opcode field consumed by the control unit.

Function
REQ-018 The FSM SHALL have four states: S_REQ, S_WAIT, S_FULL and S_DRAIN.
REQ-019 S_REQ: imem_req=1 and imem_addr=pc; on imem_ready=1 go to S_WAIT; otherwise hold.
REQ-020 S_WAIT: on imem_rvalid=1 capture if_instr<=imem_rdata, if_pc<=pc and pc<=pc+4, set if_valid=1, and go to S_FULL.
REQ-021 S_FULL: hold if_* stable while stall=1; when stall=0 the instruction is consumed, so clear if_valid next cycle and go to S_REQ.
REQ-022 At most one memory request SHALL be outstanding; imem_req=0 in S_WAIT, S_FULL and S_DRAIN.
REQ-023 Latency: with imem_ready=1 at cycle N and imem_rvalid=1 at N+1, if_valid SHALL be 1 at N+2.
REQ-024 pc+4 SHALL wrap modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Redirect SHALL take priority over every other event; pc<=redirect_pc with bits[1:0] forced to 2'b00.
REQ-026 Redirect in S_REQ: gate imem_req to 0 that cycle and stay in S_REQ with the new pc.
REQ-027 Redirect in S_WAIT with imem_rvalid=0: go to S_DRAIN and discard the next response.
REQ-028 Redirect in S_WAIT with imem_rvalid=1 in the same cycle: drop the data, keep if_valid=0, and go to S_REQ.
REQ-029 S_DRAIN: on imem_rvalid=1 go to S_REQ with no if_* update; a further redirect here only updates pc.
REQ-030 Redirect in S_FULL, with or without stall: clear if_valid next cycle and go to S_REQ.
REQ-031 if_opcode SHALL be a pure combinational slice of the if_instr register.

Reset
REQ-032 When rst=1: state<=S_REQ, pc<=RESET_PC, if_valid<=0, if_pc<=0, if_instr<=32'h0000_0013 (NOP).
REQ-033 imem_req SHALL be 0 in every cycle in which rst=1.
REQ-034 Reset mid-transaction (S_WAIT/S_DRAIN) SHALL ignore any later imem_rvalid until a new request is accepted.

Structure
REQ-035 Shared package riscv_pkg SHALL hold XLEN, NOP_INSTR, the opcode constants, and the enum fetch_state_t.
REQ-036 One sub-module, pc_reg (load/increment program counter with reset value), SHALL be instantiated; everything else is inline.

Verification
REQ-037 Reset release, imem_ready=1, rvalid one cycle later with rdata=32'h0050_0093 -> imem_addr=0, if_valid at cycle 2, if_opcode=7'b0010011, if_pc=0.
REQ-038 stall=1 for 5 cycles in S_FULL -> if_instr/if_pc constant, imem_req=0; after stall drops, the next request has addr=4.
REQ-039 Redirect to 32'h0000_0103 while in S_WAIT -> stale response discarded, next imem_addr=32'h0000_0100, if_valid never 1 for stale data.
REQ-040 Redirect coincident with imem_rvalid -> data dropped, next request at the redirect target.
REQ-041 pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-042 rst asserted in S_WAIT, then rvalid arrives -> outputs stay at reset values; first request after release uses RESET_PC.
